// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first) with a small byte FIFO on a valid/ready stream.
// rxd is double-synchronised; all samples fall at bit centres after the start edge.
module uart_rx_fifo #(
   parameter int unsigned CLK_FREQUENCY   = 96_000_000,
   parameter int unsigned BAUD            = 12_000_000,
   parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       rxd,
   output logic [7:0]                 out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       frame_err,
   output logic                       overrun,
   output logic                       busy,
   output logic [FIFO_DEPTH_LOG2:0]   fill
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQUENCY / BAUD;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned PTR_W        = FIFO_DEPTH_LOG2;
   localparam int unsigned FILL_W       = FIFO_DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH        = 2 ** FIFO_DEPTH_LOG2;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              rx_meta;
   logic              rx_s;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              cnt_last;
   logic              cnt_half;
   logic              bit_strobe;
   logic              commit;
   logic              bad_stop;
   logic              wr_en_q;
   logic [7:0]        wr_data_q;

   logic [7:0]        mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_nxt;
   logic              full;
   logic              pop;
   logic              do_write;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_s    <= rx_meta;
      end
   end

   assign cnt_last = (cnt == CNT_LAST);
   assign cnt_half = (cnt == CNT_HALF);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!rx_s) state_nxt = ST_START;
         ST_START: if (cnt_half) state_nxt = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:  if (cnt_last && bit_idx == 3'd7) state_nxt = ST_STOP;
         ST_STOP:  if (cnt_last) state_nxt = rx_s ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (rx_s) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != ST_IDLE);
      bit_strobe = (state == ST_DATA) && cnt_last;
      commit     = (state == ST_STOP) && cnt_last && rx_s;
      bad_stop   = (state == ST_STOP) && cnt_last && !rx_s;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (state_nxt != state || cnt_last)
            cnt <= '0;
         else if (state == ST_START || state == ST_DATA || state == ST_STOP)
            cnt <= cnt + CNT_W'(1);

         if (state == ST_START)
            bit_idx <= '0;
         else if (bit_strobe)
            bit_idx <= bit_idx + 3'd1;

         if (bit_strobe)
            shreg[bit_idx] <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         frame_err <= 1'b0;
      end else begin
         wr_en_q   <= commit;
         frame_err <= bad_stop;
         if (commit) wr_data_q <= shreg;
      end
   end

   assign full       = (fill == FILL_FULL);
   assign out_valid  = (fill != '0);
   assign pop        = out_valid && out_ready;
   assign do_write   = wr_en_q && (!full || pop);
   assign rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= wr_data_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill     <= '0;
         out_data <= '0;
         overrun  <= 1'b0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr <= rd_ptr_nxt;
         case ({do_write, pop})
            2'b10:   fill <= fill + FILL_W'(1);
            2'b01:   fill <= fill - FILL_W'(1);
            default: fill <= fill;
         endcase
         // Registered head: bypass the incoming byte when it lands in the next head slot.
         if (do_write && rd_ptr_nxt == wr_ptr) out_data <= wr_data_q;
         else                                  out_data <= mem[rd_ptr_nxt];
         overrun <= wr_en_q && full && !pop;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised onto rxd, a queue model of
// the FIFO predicts drops and pops, and a negedge monitor compares the stream output.
module tb_uart_rx_fifo;

   localparam int unsigned CPB   = 8;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rxd;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   logic [2:0] fill;

   uart_rx_fifo #(
      .CLK_FREQUENCY   (96_000_000),
      .BAUD            (12_000_000),
      .FIFO_DEPTH_LOG2 (2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rxd       (rxd),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy),
      .fill      (fill)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_ovr  = 0;
   int   exp_ferr = 0;
   int   got_ovr  = 0;
   int   got_ferr = 0;
   int   pops     = 0;
   bit   mon_en   = 1'b0;
   bit   rand_on  = 1'b0;
   logic [7:0] model_q[$];
   logic [7:0] commit_q[$];

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endfunction

   // Monitor: compares the cycle about to close, then applies that cycle's pop and commit to the model.
   always @(negedge clk) begin
      logic [7:0] b;
      if (reset_n && mon_en) begin
         check("fill", 32'(fill), 32'(model_q.size()));
         check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
         check("pulse_overlap", 32'(frame_err && overrun), 32'd0);
         if (frame_err) got_ferr++;
         if (overrun)   got_ovr++;
         if (out_valid && out_ready) begin
            pops++;
            if (model_q.size() == 0) check("pop_on_empty", 32'(out_valid), 32'd0);
            else                     check("out_data", 32'(out_data), 32'(model_q.pop_front()));
         end
         while (commit_q.size() > 0) begin
            b = commit_q.pop_front();
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else                        exp_ovr++;
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      rxd = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rxd = stop_bit;
      repeat (CPB - 1) @(posedge clk);
      #1;
      if (stop_bit) commit_q.push_back(d);
      else          exp_ferr++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 200 && (model_q.size() != 0 || commit_q.size() != 0); i++) @(posedge clk);
      idle(3);
      check("drain_fill", 32'(fill), 32'd0);
      check("drain_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_fill"},      32'(fill),      32'd0);
      check({tag, "_out_data"},  32'(out_data),  32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      check({tag, "_overrun"},   32'(overrun),   32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, o0, f0;
      logic [7:0] d;
      reset_n = 1'b1; rxd = 1'b1; out_ready = 1'b1;
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      mon_en = 1'b1;
      idle(4);

      // Back-to-back 0xAA, 0xBB.
      p0 = pops;
      send_frame(8'hAA, 1'b1);
      send_frame(8'hBB, 1'b1);
      check("t1_busy_after_stop", 32'(busy), 32'd0);
      idle(6);
      check("t1_pops", 32'(pops - p0), 32'd2);

      // Short glitch is rejected from START.
      f0 = got_ferr;
      rxd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      idle(20);
      check("t2_busy", 32'(busy), 32'd0);
      check("t2_ferr", 32'(got_ferr - f0), 32'd0);

      // Bad stop, held-low line, then a valid frame.
      f0 = got_ferr;
      send_frame(8'h55, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      check("t3_busy_break", 32'(busy), 32'd1);
      idle(2 * CPB);
      check("t3_busy_idle", 32'(busy), 32'd0);
      send_frame(8'h3C, 1'b1);
      idle(6);
      check("t3_ferr", 32'(got_ferr - f0), 32'd1);

      // Overrun on the fifth byte while stalled.
      o0 = got_ovr;
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      idle(4);
      check("t4_fill_full", 32'(fill), 32'd4);
      check("t4_overrun", 32'(got_ovr - o0), 32'd1);
      drain();

      // Full FIFO, pop on the exact write cycle of the fifth byte.
      o0 = got_ovr;
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
      idle(4);
      check("t5_fill_full", 32'(fill), 32'd4);
      fork
         send_frame(8'h05, 1'b1);
         begin
            repeat (10 * CPB - 1) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
         end
      join
      idle(4);
      check("t5_fill_still_full", 32'(fill), 32'd4);
      check("t5_overrun", 32'(got_ovr - o0), 32'd0);
      drain();

      // Reset mid-DATA with a stale byte queued.
      out_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      idle(4);
      rxd = 1'b0;
      repeat (CPB + 3 * CPB + 2) @(posedge clk);
      #2 reset_n = 1'b0;
      model_q.delete();
      commit_q.delete();
      #1 check_reset_outputs("midreset");
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(4);
      out_ready = 1'b1;
      p0 = pops;
      send_frame(8'hC3, 1'b1);
      idle(6);
      check("t6_pops", 32'(pops - p0), 32'd1);

      // Randomised traffic with random back-pressure and occasional bad stop bits.
      rand_on = 1'b1;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               d = 8'($urandom);
               if ($urandom_range(0, 7) == 0) begin
                  send_frame(d, 1'b0);
                  idle(CPB);
               end else begin
                  send_frame(d, 1'b1);
                  idle($urandom_range(0, 3));
               end
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      idle(6);
      drain();
      idle(4);
      check("total_frame_err", 32'(got_ferr), 32'(exp_ferr));
      check("total_overrun", 32'(got_ovr), 32'(exp_ovr));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable UART receiver for the FPGA side of the serial link: 8N1 framing, LSB first, one clock domain.
- Recovers bytes from the asynchronous rxd line and buffers them in a small FIFO.
- Presents bytes on a valid/ready stream interface to downstream logic (loopback, command parser).
- Also used in benches as the decoding monitor on a DUT's txd line.

Parameters:
- CLK_FREQUENCY, 96_000_000, system clock frequency in Hz.
- BAUD, 12_000_000, line rate in bits/s. CLKS_PER_BIT = CLK_FREQUENCY/BAUD (integer division); must be >= 4.
- FIFO_DEPTH_LOG2, 2, FIFO holds 2**FIFO_DEPTH_LOG2 bytes.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line; idle high; asynchronous to clk.
- out_data  output  8  byte at FIFO head; valid only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts; a pop occurs on a cycle with out_valid & out_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte received while FIFO full, byte dropped.
- busy  output  1  receive FSM not in IDLE.
- fill  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (async assert; deassert takes effect on the next clk edge):
  - out_valid=0, frame_err=0, overrun=0, busy=0, fill=0, out_data=0.
  - Synchronizer flops preset to 1; FSM=IDLE; bit counter and clock counter=0.
  - Reset mid-frame discards the partial byte and empties the FIFO.
- Input sync: rxd passes through 2 flops (rx_s). All FSM decisions use rx_s; latency 2 clocks.
- FSM states: IDLE, START, DATA, STOP, BREAK. The clock counter cnt counts 0..CLKS_PER_BIT-1.
  - IDLE: rx_s=0 -> START, cnt=0.
  - START: when cnt = CLKS_PER_BIT/2 - 1, sample rx_s.
    - 1 -> IDLE (glitch rejected, no output).
    - 0 -> DATA, cnt=0, bit index=0.
  - DATA: when cnt = CLKS_PER_BIT-1, shift rx_s into the shift register at bit[index] (LSB first) and set cnt=0. After index 7 -> STOP.
  - STOP: when cnt = CLKS_PER_BIT-1, sample rx_s.
    - 1 -> commit the byte, then IDLE.
    - 0 -> frame_err pulse, byte discarded, then BREAK.
  - BREAK: remain until rx_s=1, then IDLE. This stops a held-low line from being decoded as repeated 0x00 frames.
  - All samples fall at bit centres: offset (CLKS_PER_BIT/2) + k*CLKS_PER_BIT clocks after the start-edge detection.
- Commit timing:
  - A committed byte is written to the FIFO on the cycle after the stop-bit sample.
  - out_valid is high one cycle after that write when the FIFO was empty.
  - Receive FSM returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected.
- FIFO:
  - Circular buffer with wrapping read/write pointers of FIFO_DEPTH_LOG2 bits.
  - fill counts 0..2**FIFO_DEPTH_LOG2.
  - out_data is registered from the head entry.
- Simultaneous events:
  - Write and pop in the same cycle with FIFO full: the write is accepted; fill is unchanged; no overrun.
  - Write and pop in the same cycle with FIFO empty: cannot occur, because out_valid=0.
  - Write while full without a pop: overrun pulse; FIFO contents unchanged.
- frame_err and overrun never pulse in the same cycle.
- busy=1 in START, DATA, STOP and BREAK.
- The receiver never stalls the line: reception continues regardless of out_ready.

Test Plan:
- Defaults, out_ready=1, rxd drives 0xAA then 0xBB back-to-back (8 clocks/bit, 20-bit serial stream incl. start/stop) -> out_valid pulses twice, out_data 0xAA then 0xBB, frame_err=overrun=0, busy=0 after the last stop bit.
- rxd low for 2 clocks then high (glitch shorter than half a bit) -> FSM returns to IDLE from START, no out_valid, no frame_err.
- Frame 0x55 with stop bit forced 0, rxd held low 30 clocks, then a valid 0x3C -> one frame_err pulse, FSM stays in BREAK until rxd high, then out_data=0x3C; 0x55 never appears.
- out_ready=0, send 5 bytes 0x01..0x05 (depth 4) -> fill reaches 4, one overrun pulse on the 5th; set out_ready=1 and FIFO drains 0x01..0x04 in order, then out_valid=0, fill=0.
- FIFO full (4 bytes), out_ready pulsed high on the exact cycle the 5th byte commits -> no overrun, fill stays 4, drain order 0x02,0x03,0x04,0x05.
- Assert reset_n=0 mid-DATA of a frame, release, send 0xC3 -> outputs immediately at reset values, first output byte is 0xC3, no stale data.
